// File: rtl/usi_pkg.sv
// usi_pkg: shared definitions for the USI transfer sequencer.
//   - FSM state encoding (ST_IDLE, ST_LOAD, ST_SHIFT, ST_DONE)
//   - mode_sel encodings
//   - bit positions of the fields inside the parameters register
//   - widest supported frame (MAX_BITS)
//   - cfg_legal(): start-acceptance check on the live register values
package usi_pkg;

  localparam int MAX_BITS = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } usi_state_e;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_TX     = 2'd1;
  localparam logic [1:0] MODE_RX     = 2'd2;
  localparam logic [1:0] MODE_DUPLEX = 2'd3;

  localparam int PARAM_LEN_LSB  = 0;
  localparam int PARAM_LEN_MSB  = 5;
  localparam int PARAM_MSBF_BIT = 6;
  localparam int PARAM_LOOP_BIT = 8;

  function automatic logic cfg_legal(input logic [1:0]  mode,
                                     input logic [31:0] div,
                                     input logic [5:0]  len,
                                     input int          max_len);
    return (mode != MODE_OFF) && (div != 32'd0) && (len != 6'd0) && (int'(len) <= max_len);
  endfunction

endpackage

// File: rtl/usi_ctrl_unit_baud_gen.sv
// usi_baud_gen: bit-rate tick generator for the USI sequencer.
// Counts CLK cycles while enabled and pulses tick on the cycle the count
// reaches clkdiv-1, wrapping to 0 on that same edge.
// Ports:
//   CLK     in   system clock
//   RST     in   synchronous active-high reset
//   en      in   count enable (sequencer in SHIFT)
//   clr     in   synchronous counter clear (sequencer in LOAD)
//   clkdiv  in   CLK cycles per serial bit, must be non-zero
//   tick    out  one-cycle bit-boundary pulse
module usi_baud_gen
  import usi_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] clkdiv,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;

  assign tick = en && (cnt_q == (clkdiv - CNT_W'(1)));

  always_ff @(posedge CLK) begin
    if (RST || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/usi_ctrl_unit.sv
// usi_ctrl_unit: transfer sequencer for the USI peripheral.
// Accepts a start strobe from the register file, snapshots the transfer
// configuration, shifts tx_data out on tx_out and samples rx_in on every
// bit tick, then reports done / rx_word / rx_valid. Protocol violations
// (start while busy, start with an illegal config) set a sticky error.
// Build option: define USI_LOOPBACK_EN to let parameters[8] route the
// internal tx_out into the RX sampler instead of rx_in.
// Ports:
//   CLK, RST          clock, synchronous active-high reset
//   mode_sel          0 off, 1 TX, 2 RX, 3 duplex
//   clkdiv            CLK cycles per bit (0 illegal)
//   parameters        [5:0] frame length, [6] msb_first, [8] loopback
//   tx_data, start    word to send and its one-cycle request
//   err_clr           clears the sticky error
//   rx_in / tx_out    serial pins (tx_out idles high)
//   bit_tick, busy, done, rx_word, rx_valid, ctrl_unit_error  status
//
// state    | meaning
// ST_IDLE  | waiting for start, tx_out high
// ST_LOAD  | config captured, first bit presented, counters cleared
// ST_SHIFT | divider running, one bit per tick
// ST_DONE  | one-cycle completion, rx_word/rx_valid published
module usi_ctrl_unit
  import usi_pkg::*;
#(
  parameter int MAX_BITS = usi_pkg::MAX_BITS,
  parameter int CNT_W    = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  mode_sel,
  input  logic [31:0] clkdiv,
  input  logic [31:0] parameters,
  input  logic [31:0] tx_data,
  input  logic        start,
  input  logic        err_clr,
  input  logic        rx_in,
  output logic        tx_out,
  output logic        bit_tick,
  output logic        busy,
  output logic        done,
  output logic [31:0] rx_word,
  output logic        rx_valid,
  output logic        ctrl_unit_error
);

  localparam int IDX_W = $clog2(MAX_BITS);

  usi_state_e          state_q;
  logic [1:0]          mode_q;
  logic [5:0]          len_q;
  logic                msbf_q;
  logic [31:0]         clkdiv_q;
  logic [MAX_BITS-1:0] tx_sr;
  logic [MAX_BITS-1:0] rx_sr;
  logic [MAX_BITS-1:0] rx_next;
  logic [5:0]          bit_cnt;
  logic [31:0]         rx_word_q;
  logic                error_q;

  logic                tick;
  logic                last_tick;
  logic                legal;
  logic                err_evt;
  logic                rx_bit;
  logic [IDX_W-1:0]    pos;

  assign legal = cfg_legal(mode_sel, clkdiv, parameters[PARAM_LEN_MSB:PARAM_LEN_LSB], MAX_BITS);

  // Any start outside IDLE is rejected, as is a start with a bad config.
  assign err_evt = start && ((state_q != ST_IDLE) || !legal);

  // The TX and RX registers are addressed by the bit counter rather than
  // physically shifted; the frame position of the current bit depends on
  // the captured bit order.
  assign pos = msbf_q ? IDX_W'(len_q - 6'd1 - bit_cnt) : IDX_W'(bit_cnt);

  assign last_tick = tick && (bit_cnt == (len_q - 6'd1));

  usi_baud_gen #(
    .CNT_W (CNT_W)
  ) u_baud (
    .CLK    (CLK),
    .RST    (RST),
    .en     (state_q == ST_SHIFT),
    .clr    (state_q == ST_LOAD),
    .clkdiv (CNT_W'(clkdiv_q)),
    .tick   (tick)
  );

  always_comb begin
    tx_out = 1'b1;
    if (((state_q == ST_LOAD) || (state_q == ST_SHIFT)) && (mode_q != MODE_RX)) begin
      tx_out = tx_sr[pos];
    end
  end

`ifdef USI_LOOPBACK_EN
  logic loop_q;
  logic unused_param;
  assign unused_param = ^{parameters[31:9], parameters[7]};
  assign rx_bit = loop_q ? tx_out : rx_in;

  always_ff @(posedge CLK) begin
    if (RST) begin
      loop_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && start && legal) begin
      loop_q <= parameters[PARAM_LOOP_BIT];
    end
  end
`else
  logic unused_param;
  assign unused_param = ^parameters[31:7];
  assign rx_bit = rx_in;
`endif

  // Received frame including the bit sampled on this tick, so the final
  // tick can publish a complete word straight into rx_word.
  always_comb begin
    rx_next      = rx_sr;
    rx_next[pos] = rx_bit;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_OFF;
      len_q     <= '0;
      msbf_q    <= 1'b0;
      clkdiv_q  <= '0;
      tx_sr     <= '0;
      rx_sr     <= '0;
      bit_cnt   <= '0;
      rx_word_q <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start && legal) begin
            mode_q   <= mode_sel;
            len_q    <= parameters[PARAM_LEN_MSB:PARAM_LEN_LSB];
            msbf_q   <= parameters[PARAM_MSBF_BIT];
            clkdiv_q <= clkdiv;
            tx_sr    <= MAX_BITS'(tx_data);
            rx_sr    <= '0;
            // Cleared here so LOAD already presents frame bit 0.
            bit_cnt  <= '0;
            state_q  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            rx_sr   <= rx_next;
            bit_cnt <= bit_cnt + 6'd1;
            if (last_tick) begin
              state_q <= ST_DONE;
              if (mode_q[1]) begin
                rx_word_q <= 32'(rx_next);
              end
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // A new error event wins over a simultaneous clear.
      if (err_evt) begin
        error_q <= 1'b1;
      end else if (err_clr) begin
        error_q <= 1'b0;
      end
    end
  end

  assign bit_tick        = tick;
  assign busy            = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
  assign done            = (state_q == ST_DONE);
  assign rx_valid        = (state_q == ST_DONE) && mode_q[1];
  assign rx_word         = rx_word_q;
  assign ctrl_unit_error = error_q;

endmodule

// File: tb/tb_usi_ctrl_unit.sv
module tb_usi_ctrl_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [1:0]  mode_sel;
  logic [31:0] clkdiv;
  logic [31:0] parameters;
  logic [31:0] tx_data;
  logic        start;
  logic        err_clr;
  logic        rx_in;
  logic        tx_out;
  logic        bit_tick;
  logic        busy;
  logic        done;
  logic [31:0] rx_word;
  logic        rx_valid;
  logic        ctrl_unit_error;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  usi_ctrl_unit dut (
    .CLK             (CLK),
    .RST             (RST),
    .mode_sel        (mode_sel),
    .clkdiv          (clkdiv),
    .parameters      (parameters),
    .tx_data         (tx_data),
    .start           (start),
    .err_clr         (err_clr),
    .rx_in           (rx_in),
    .tx_out          (tx_out),
    .bit_tick        (bit_tick),
    .busy            (busy),
    .done            (done),
    .rx_word         (rx_word),
    .rx_valid        (rx_valid),
    .ctrl_unit_error (ctrl_unit_error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a transfer is described only by how many cycles have
  // passed since acceptance (m_t = 1 in the first cycle after start).
  // Tick k falls on m_t = 1 + k*D, busy spans m_t = 1 .. N*D+1, done is N*D+2.
  bit        m_act;
  int        m_t, m_D, m_N;
  bit [1:0]  m_mode;
  bit        m_msbf, m_loop;
  bit [31:0] m_data, m_rx, m_rxword;
  bit        m_err;

  // {busy, done, tick, tx, rx_valid}
  function automatic bit [4:0] exp_out();
    int last, j, p;
    bit [4:0] r;
    r = 5'b00010;
    if (m_act) begin
      last = m_N * m_D + 1;
      if (m_t <= last) begin
        r[4] = 1'b1;
        if (m_t >= 2 && ((m_t - 1) % m_D) == 0) r[2] = 1'b1;
        if (m_mode != 2'd2) begin
          j = (m_t < 2) ? 0 : (m_t - 2) / m_D;
          p = m_msbf ? (m_N - 1 - j) : j;
          r[1] = m_data[p];
        end
      end else begin
        r[3] = 1'b1;
        r[0] = m_mode[1];
      end
    end
    return r;
  endfunction

  always @(posedge CLK) begin
    bit [4:0] e;
    bit ev, smp;
    int k, pos;
    e = exp_out();
    if (RST) begin
      m_act = 0; m_err = 0; m_rxword = 0; m_rx = 0;
    end else begin
      ev = 0;
      if (m_act) begin
        if (e[2]) begin
          k   = (m_t - 1) / m_D;
          pos = m_msbf ? (m_N - k) : (k - 1);
          smp = rx_in;
`ifdef USI_LOOPBACK_EN
          if (m_loop) smp = e[1];
`endif
          m_rx[pos] = smp;
        end
        if (m_t == m_N * m_D + 1 && m_mode[1]) m_rxword = m_rx;
        if (start) ev = 1;
        if (m_t == m_N * m_D + 2) m_act = 0;
        else m_t++;
      end else if (start) begin
        if (mode_sel != 0 && clkdiv != 0 && parameters[5:0] >= 1 && parameters[5:0] <= 32) begin
          m_act  = 1; m_t = 1;
          m_mode = mode_sel; m_D = int'(clkdiv); m_N = int'(parameters[5:0]);
          m_msbf = parameters[6]; m_loop = parameters[8];
          m_data = tx_data; m_rx = 0;
        end else begin
          ev = 1;
        end
      end
      if (ev) m_err = 1;
      else if (err_clr) m_err = 0;
    end
  end

  always @(negedge CLK) begin
    bit [4:0] e;
    if (chk_on) begin
      e = exp_out();
      chk("busy", busy, e[4]);
      chk("done", done, e[3]);
      chk("bit_tick", bit_tick, e[2]);
      chk("tx_out", tx_out, e[1]);
      chk("rx_valid", rx_valid, e[0]);
      chk("error", ctrl_unit_error, m_err);
      chk("rx_word", rx_word, m_rxword);
    end
  end

  task automatic clr_err();
    err_clr = 1;
    @(posedge CLK); #1;
    err_clr = 0;
  endtask

  // Runs one transfer from a start pulse in cycle 0 for `limit` cycles.
  // rx_in carries rxpat[j] for the whole window of frame bit j.
  task automatic xfer(input bit [1:0] md, input bit [31:0] dv, input bit [5:0] n,
                      input bit mf, input bit lp, input bit [31:0] data,
                      input bit [31:0] rxpat, input int restart, input int limit,
                      output int done_c, output int err_c, output bit [31:0] word,
                      output bit rxv, output bit bsy, output bit [63:0] trace);
    done_c = -1; err_c = -1; word = 0; rxv = 0; bsy = 0; trace = '1;
    mode_sel = md; clkdiv = dv; parameters = {23'd0, lp, 1'b0, mf, n};
    tx_data = data; start = 1; rx_in = rxpat[0];
    @(posedge CLK); #1;
    start = 0;
    for (int c = 1; c <= limit; c++) begin
      int j;
      j = (c < 2 || dv == 0) ? 0 : (c - 2) / int'(dv);
      if (j > 31) j = 31;
      rx_in = rxpat[j];
      if (c == restart) begin
        start = 1; tx_data = ~data; parameters = 32'h0000_0043; clkdiv = 32'd7;
      end
      @(negedge CLK);
      if (c < 64) trace[c] = tx_out;
      if (busy) bsy = 1;
      if (ctrl_unit_error && err_c < 0) err_c = c;
      if (done && done_c < 0) begin
        done_c = c; word = rx_word; rxv = rx_valid;
      end
      @(posedge CLK); #1;
      start = 0;
    end
  endtask

  initial begin
    int dc, ec;
    bit [31:0] w, pat;
    bit rv, bs;
    bit [63:0] tr;
    bit s1[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    RST = 1; start = 0; err_clr = 0; mode_sel = 0; clkdiv = 0;
    parameters = 0; tx_data = 0; rx_in = 0;
    repeat (2) @(posedge CLK);
    #1; RST = 0; chk_on = 1;
    @(negedge CLK);
    chk("rst_tx_out", tx_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_error", ctrl_unit_error, 0);
    chk("rst_rx_word", rx_word, 0);
    @(posedge CLK); #1;

    // TX-only, D=2, N=8, LSB-first, 0xA5
    xfer(2'd1, 32'd2, 6'd8, 1'b0, 1'b0, 32'hA5, 32'h0, -1, 22, dc, ec, w, rv, bs, tr);
    chk("t1_done_cycle", dc, 18);
    chk("t1_rx_valid", rv, 0);
    for (int k = 0; k < 8; k++) chk("t1_tx_bit", tr[2 + 2 * k], s1[k]);
    chk("t1_tx_idle_at_done", tr[18], 1);

    // Duplex, D=1, N=4, MSB-first, rx 1,0,1,1
    xfer(2'd3, 32'd1, 6'd4, 1'b1, 1'b0, 32'h0, 32'hD, -1, 10, dc, ec, w, rv, bs, tr);
    chk("t2_done_cycle", dc, 6);
    chk("t2_rx_word", w, 32'h0000_000B);
    chk("t2_rx_valid", rv, 1);

    // clkdiv = 0 is refused
    xfer(2'd1, 32'd0, 6'd8, 1'b0, 1'b0, 32'h55, 32'h0, -1, 6, dc, ec, w, rv, bs, tr);
    chk("t3_no_done", dc, -1);
    chk("t3_never_busy", bs, 0);
    chk("t3_err_cycle", ec, 1);
    @(negedge CLK);
    chk("t3_err_held", ctrl_unit_error, 1);
    @(posedge CLK); #1;
    clr_err();
    @(negedge CLK);
    chk("t3_err_cleared", ctrl_unit_error, 0);
    @(posedge CLK); #1;

    // second start mid-transfer
    xfer(2'd1, 32'd2, 6'd8, 1'b0, 1'b0, 32'hA5, 32'h0, 6, 22, dc, ec, w, rv, bs, tr);
    chk("t4_done_cycle", dc, 18);
    chk("t4_err_cycle", ec, 7);
    for (int k = 0; k < 8; k++) chk("t4_tx_bit", tr[2 + 2 * k], s1[k]);
    clr_err();

    // reset during SHIFT
    mode_sel = 2'd1; clkdiv = 32'd3; parameters = 32'd6; tx_data = $urandom; start = 1;
    @(posedge CLK); #1;
    start = 0;
    repeat (7) @(posedge CLK);
    #1; RST = 1;
    @(posedge CLK); #1;
    RST = 0;
    @(negedge CLK);
    chk("t5_busy_after_rst", busy, 0);
    chk("t5_tx_after_rst", tx_out, 1);
    @(posedge CLK); #1;
    bs = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge CLK);
      if (done) bs = 1;
      @(posedge CLK); #1;
    end
    chk("t5_no_done", bs, 0);
    pat = $urandom;
    xfer(2'd3, 32'd1, 6'd5, 1'b0, 1'b0, $urandom, pat, -1, 10, dc, ec, w, rv, bs, tr);
    chk("t5_next_done_cycle", dc, 7);
    chk("t5_next_rx_word", w, {27'd0, pat[4:0]});

    // loopback request
    xfer(2'd3, 32'd2, 6'd8, 1'b0, 1'b1, 32'h3C, 32'h0, -1, 22, dc, ec, w, rv, bs, tr);
    chk("t6_done_cycle", dc, 18);
`ifdef USI_LOOPBACK_EN
    chk("t6_loop_rx_word", w, 32'h0000_003C);
`else
    chk("t6_loop_rx_word", w, 32'h0000_0000);
`endif

    // randomized traffic, checked every cycle by the model
    for (int i = 0; i < 5000; i++) begin
      int r;
      RST     = ($urandom_range(0, 599) == 0);
      start   = ($urandom_range(0, 24) == 0);
      err_clr = ($urandom_range(0, 29) == 0);
      mode_sel = 2'($urandom_range(0, 3));
      r = $urandom_range(0, 9);
      clkdiv = (r == 0) ? 32'd0 : 32'($urandom_range(1, 4));
      parameters = $urandom;
      parameters[5:0] = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63))
                                                    : 6'($urandom_range(1, 32));
      tx_data = $urandom;
      rx_in   = 1'($urandom_range(0, 1));
      @(posedge CLK); #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
